// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encoding and control field codes for the multi-cycle MIPS controller
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC     = 4'd3,
      S_RWB      = 4'd4,
      S_MEMADDR  = 4'd5,
      S_MEMREAD  = 4'd6,
      S_MEMWB    = 4'd7,
      S_MEMWRITE = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10,
      S_ADDIEX   = 4'd11,
      S_ADDIWB   = 4'd12,
      S_TRAP     = 4'd13
   } state_t;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_EXEC;
         OP_LW, OP_SW: return S_MEMADDR;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_ADDIEX;
         default:      return S_TRAP;
      endcase
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - consecutive not-ready cycle counter for memory states
module mem_wait_timer #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic limit_hit
);

   logic [9:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 10'd1;
      end
   end

   // High on the cycle that would be the LIMIT-th consecutive not-ready cycle.
   assign limit_hit = (count == 10'(LIMIT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with retire counter and trap handling
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 255,
   parameter int CNT_W      = 32
) (
   input  logic             ClkIn,
   input  logic             Rst,
   input  logic [5:0]       Opcode,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       PCSource,
   output logic             Halted,
   output logic             BusError,
   output logic [CNT_W-1:0] InstrCount
);

   state_t           state, nxt;
   logic [CNT_W-1:0] instr_cnt;
   logic             bus_error;
   logic             mem_state, limit_hit, timeout, retire;
   logic             unused_zero;

   // The datapath gates PCWriteCond with Zero itself.
   assign unused_zero = Zero;

   assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
   assign timeout   = mem_state && !MemReady && limit_hit;
   assign retire    = (state == S_RWB) || (state == S_MEMWB) || (state == S_BRANCH) ||
                      (state == S_JUMP) || (state == S_ADDIWB) ||
                      ((state == S_MEMWRITE) && MemReady);

   mem_wait_timer #(.LIMIT(WAIT_LIMIT)) u_timer (
      .clk       (ClkIn),
      .rst_n     (Rst),
      .clear     (nxt != state),
      .enable    (mem_state && !MemReady),
      .limit_hit (limit_hit)
   );

   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     nxt = S_FETCH;
         S_FETCH:    if (MemReady) nxt = S_DECODE; else if (timeout) nxt = S_TRAP;
         S_DECODE:   nxt = decode_next(Opcode);
         S_EXEC:     nxt = S_RWB;
         S_MEMADDR:  nxt = (Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (MemReady) nxt = S_MEMWB; else if (timeout) nxt = S_TRAP;
         S_MEMWRITE: if (MemReady) nxt = S_FETCH; else if (timeout) nxt = S_TRAP;
         S_ADDIEX:   nxt = S_ADDIWB;
         S_RWB, S_MEMWB, S_BRANCH, S_JUMP, S_ADDIWB: nxt = S_FETCH;
         default:    nxt = S_TRAP;
      endcase
   end

   always_ff @(posedge ClkIn or negedge Rst) begin
      if (!Rst) begin
         state     <= S_IDLE;
         instr_cnt <= '0;
         bus_error <= 1'b0;
      end else begin
         state <= nxt;
         if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
         if (timeout) bus_error <= 1'b1;
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            IRWrite = MemReady;
            PCWrite = MemReady;
         end
         S_DECODE:   ALUSrcB = SRCB_IMMSH2;
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = ALUOP_FUNCT;
         end
         S_RWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMADDR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMREAD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            PCWrite  = 1'b1;
            PCSource = PCSRC_JUMP;
         end
         S_ADDIWB:   RegWrite = 1'b1;
         default: ;
      endcase
   end

   assign Halted     = (state == S_TRAP);
   assign BusError   = bus_error;
   assign InstrCount = instr_cnt;

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the shared MIPS datapath (PC, IR/MDR, register file, ALU, unified memory port) one instruction at a time.
It replaces the single-cycle combinational control when instruction and data memory are merged behind one port with variable latency.
It also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
WAIT_LIMIT, 255, maximum consecutive cycles a memory state may wait for MemReady before a bus-error trap (1..1023).
CNT_W, 32, width of the retired-instruction counter.

Ports:
ClkIn  input  1  single clock, rising-edge.
Rst  input  1  asynchronous active-low reset; forces state IDLE, counters to 0.
Opcode  input  6  IR[31:26] from the datapath.
Zero  input  1  ALU zero flag.
MemReady  input  1  memory port completes the current access this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load if Zero.
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
MemRead  output  1  memory read request.
MemWrite  output  1  memory write request.
IRWrite  output  1  load IR from memory data.
MemtoReg  output  1  register write data: 0 = ALUOut, 1 = MDR.
RegDst  output  1  write register: 0 = rt, 1 = rd.
RegWrite  output  1  register file write.
ALUSrcA  output  1  0 = PC, 1 = rs.
ALUSrcB  output  2  00 = rt, 01 = const 4, 10 = signext imm, 11 = signext imm << 2.
ALUOp  output  2  00 = add, 01 = sub, 10 = funct field.
PCSource  output  2  00 = ALU, 01 = ALUOut, 10 = jump target.
Halted  output  1  sticky: FSM is in TRAP.
BusError  output  1  sticky: the trap cause was a memory timeout.
InstrCount  output  CNT_W  number of retired instructions.

Behaviour:
- Reset (Rst = 0, asynchronous):
  - State IDLE; InstrCount = 0; wait counter = 0; Halted = 0; BusError = 0.
  - All outputs 0 while in IDLE.
  - IDLE goes to FETCH on the first clock after Rst deasserts.
- Output style: outputs are Moore-decoded from the state, except that write strobes in memory states are qualified by MemReady (Mealy), as listed below.
- FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = PCWrite = MemReady.
  - Stays in FETCH while MemReady = 0; goes to DECODE when MemReady = 1.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC
  - 100011 / 101011 -> MEMADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDIEX
  - any other opcode -> TRAP
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; next RWB.
- RWB: RegDst = 1, RegWrite = 1, MemtoReg = 0; next FETCH.
- MEMADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; next MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: MemRead = 1, IorD = 1; waits for MemReady, then MEMWB.
- MEMWB: RegDst = 0, MemtoReg = 1, RegWrite = 1; next FETCH.
- MEMWRITE: IorD = 1, MemWrite = 1 held until the MemReady cycle; next FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01; next FETCH.
- JUMP: PCWrite = 1, PCSource = 10; next FETCH.
- ADDIEX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; next ADDIWB.
- ADDIWB: RegDst = 0, MemtoReg = 0, RegWrite = 1; next FETCH.
- Latency with MemReady tied to 1:
  - R-type 4 cycles; lw 5; sw 4; beq 3; j 3; addi 4.
  - Each wait cycle adds 1.
- Retirement: InstrCount increments by 1 on leaving RWB, MEMWB, BRANCH, JUMP, ADDIWB, or on the MemReady cycle of MEMWRITE. It wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entering any memory state (FETCH, MEMREAD, MEMWRITE).
  - Increments each cycle the FSM stays in that state with MemReady = 0.
  - If it reaches WAIT_LIMIT with MemReady still 0, next state is TRAP and BusError is set.
  - MemReady arriving on the limit cycle wins: normal transition, no error.
- TRAP: all strobes 0, Halted = 1. The FSM stays in TRAP until reset.
- Reset mid-instruction: immediate return to IDLE. No write strobe is asserted in the cycle the reset is applied.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - state encoding (4-bit)
  - ALUOp, ALUSrcB and PCSource codes
- One sub-module, mem_wait_timer: wait counter with clear/enable inputs and a limit-reached output.

Test Plan:
- MemReady = 1, opcode 000000 after reset -> IDLE, FETCH, DECODE, EXEC, RWB, FETCH; RegWrite = 1, RegDst = 1 only in RWB; InstrCount = 1.
- lw with MemReady low for 3 cycles in MEMREAD -> MEMREAD lasts 4 cycles, total 8 cycles; MemtoReg = 1 and RegWrite = 1 in MEMWB.
- beq with Zero = 1, then with Zero = 0 -> PCWriteCond = 1, PCSource = 01 in BRANCH both times; 3 cycles each; InstrCount +2.
- Opcode 111111 -> TRAP after DECODE; Halted = 1, BusError = 0, all strobes 0 for 20 cycles; Rst pulse returns to IDLE with Halted = 0.
- WAIT_LIMIT = 4, MemReady held 0 in FETCH -> TRAP after 4 wait cycles, BusError = 1. Repeat with MemReady = 1 on the 4th wait cycle -> DECODE, no error.
- Rst asserted during MEMWRITE with MemReady = 0 -> MemWrite drops asynchronously; state IDLE; InstrCount = 0.
